// File: rtl/nios_led_pkg.sv
// nios_led_pkg: shared constants for the LED controller slice.
//   ADDR_*   : Avalon-MM word addresses of the controller registers
//   NUM_REGS : number of decoded registers; addresses 6 and 7 are unused
package nios_led_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_BLINK  = 3'd3;
  localparam logic [2:0] ADDR_DIV    = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int NUM_REGS = 6;

endpackage

// File: rtl/nios_led_blink_div.sv
// nios_led_blink_div: blink prescaler producing the shared blink phase.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   div     : half-period in cycles minus 1 (0 halts blinking, phase held at 1)
//   div_wr  : divisor is being written this cycle; restarts the count
//   cnt     : current count, always in 0..div
//   phase   : blink phase, 1 = enabled LEDs on
module nios_led_blink_div #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  input  logic             div_wr,
  output logic [DIV_W-1:0] cnt,
  output logic             phase
);

  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic             phase_reg, phase_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b1;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

  // A divisor write wins over a terminal-count toggle on the same edge so
  // that the new period always starts from a known on-phase.
  always_comb begin
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    if (div_wr || (div == '0)) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (cnt_reg == div) begin
      cnt_next   = '0;
      phase_next = ~phase_reg;
    end else begin
      cnt_next   = cnt_reg + 1'b1;
    end
  end

  assign cnt   = cnt_reg;
  assign phase = phase_reg;

endmodule

// File: rtl/nios_led_ctrl.sv
// nios_led_ctrl: Avalon-MM LED output register with atomic set/clear,
// per-bit blink enable and a programmable blink prescaler.
//   clk        : system clock
//   reset_n    : synchronous active-low reset
//   address    : register word address
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data; bits above each register width ignored
//   readdata   : zero-latency read mux of the registers, upper bits 0
//   out_port   : registered LED drive
module nios_led_ctrl
  import nios_led_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int          DIV_W      = 24,
  parameter int unsigned DIV_RESET  = 5000000,
  parameter logic [31:0] DATA_RESET = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr;
  logic             div_wr;
  logic [WIDTH-1:0] wdata_w;

  logic [WIDTH-1:0] data_reg,  data_next;
  logic [WIDTH-1:0] blink_reg, blink_next;
  logic [DIV_W-1:0] div_reg,   div_next;
  logic [WIDTH-1:0] out_reg,   out_next;

  logic [DIV_W-1:0] cnt;
  logic             phase;

  // Bits of writedata beyond the register widths are deliberately dropped.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr      = chipselect & ~write_n;
  assign div_wr  = wr && (address == ADDR_DIV);
  assign wdata_w = writedata[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_reg  <= WIDTH'(DATA_RESET);
      blink_reg <= '0;
      div_reg   <= DIV_W'(DIV_RESET);
      out_reg   <= '0;
    end else begin
      data_reg  <= data_next;
      blink_reg <= blink_next;
      div_reg   <= div_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    data_next  = data_reg;
    blink_next = blink_reg;
    div_next   = div_reg;
    if (wr) begin
      case (address)
        ADDR_DATA:  data_next  = wdata_w;
        ADDR_SET:   data_next  = data_reg | wdata_w;
        ADDR_CLR:   data_next  = data_reg & ~wdata_w;
        ADDR_BLINK: blink_next = wdata_w;
        ADDR_DIV:   div_next   = writedata[DIV_W-1:0];
        default:    ;
      endcase
    end
  end

  nios_led_blink_div #(
    .DIV_W (DIV_W)
  ) u_blink_div (
    .clk     (clk),
    .reset_n (reset_n),
    .div     (div_reg),
    .div_wr  (div_wr),
    .cnt     (cnt),
    .phase   (phase)
  );

  // Output is registered from the current register state, so a write or a
  // phase toggle on one edge reaches the LEDs on the following edge.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
    assign out_next[gi] = data_reg[gi] & (~blink_reg[gi] | phase);
  end

  assign out_port = out_reg;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_reg);
      ADDR_BLINK:  readdata = 32'(blink_reg);
      ADDR_DIV:    readdata = 32'(div_reg);
      ADDR_STATUS: readdata = 32'({cnt, phase});
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_led_ctrl.sv
// tb_nios_led_ctrl: scoreboard bench for nios_led_ctrl (WIDTH=8, DIV_W=24,
// DATA_RESET=8'hA5). Each bus cycle pushes the expected out_port from a
// behavioural model; the value is popped and compared after the edge.
module tb_nios_led_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];

  // Behavioural model state
  logic [7:0]  m_data  = 8'hA5;
  logic [7:0]  m_blink = 8'h00;
  logic [23:0] m_div   = 24'd5000000;
  logic [23:0] m_cnt   = 24'd0;
  logic        m_phase = 1'b1;

  always #5 clk = ~clk;

  nios_led_ctrl #(
    .WIDTH      (8),
    .DIV_W      (24),
    .DIV_RESET  (5000000),
    .DATA_RESET (32'hA5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, predict, clock, compare out_port.
  task automatic step(input logic rst_n_i, input logic we, input logic [2:0] a, input logic [31:0] d);
    logic [7:0]  n_data, n_blink, n_out;
    logic [23:0] n_div, n_cnt;
    logic        n_phase;
    reset_n    = rst_n_i;
    chipselect = we;
    write_n    = ~we;
    address    = a;
    writedata  = d;
    if (!rst_n_i) begin
      n_data = 8'hA5; n_blink = 8'h00; n_div = 24'd5000000;
      n_cnt = 24'd0; n_phase = 1'b1; n_out = 8'h00;
    end else begin
      n_out   = m_data & (~m_blink | {8{m_phase}});
      n_data  = m_data;
      n_blink = m_blink;
      n_div   = m_div;
      if (we) begin
        case (a)
          3'd0: n_data  = d[7:0];
          3'd1: n_data  = m_data | d[7:0];
          3'd2: n_data  = m_data & ~d[7:0];
          3'd3: n_blink = d[7:0];
          3'd4: n_div   = d[23:0];
          default: ;
        endcase
      end
      if ((we && a == 3'd4) || m_div == 24'd0) begin
        n_cnt = 24'd0; n_phase = 1'b1;
      end else if (m_cnt == m_div) begin
        n_cnt = 24'd0; n_phase = ~m_phase;
      end else begin
        n_cnt = m_cnt + 24'd1; n_phase = m_phase;
      end
    end
    exp_q.push_back(n_out);
    @(posedge clk);
    #1;
    m_data = n_data; m_blink = n_blink; m_div = n_div; m_cnt = n_cnt; m_phase = n_phase;
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("[TB] t=%0t rst_n=%0b wr=%0b addr=%0d wdata=0x%08h out_port=0x%02h",
             $time, rst_n_i, we, a, d, out_port);
    if (exp_q.size() == 0) check("sb_empty", 32'd0, 32'd1);
    else check("out_port", {24'd0, out_port}, {24'd0, exp_q.pop_front()});
  endtask

  task automatic rd(input logic [2:0] a, input string tag, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  function automatic logic [31:0] st(input logic [23:0] c, input logic p);
    return {7'd0, c, p};
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // Reset
    repeat (3) step(1'b0, 1'b0, 3'd0, 32'h0);
    check("rst_out", {24'd0, out_port}, 32'h0);
    rd(3'd4, "rst_div", 32'd5000000);
    rd(3'd5, "rst_status", st(24'd0, 1'b1));
    rd(3'd0, "rst_data", 32'hA5);
    step(1'b1, 1'b0, 3'd0, 32'h0);
    check("rel_out", {24'd0, out_port}, 32'hA5);

    // DATA / SET / CLR
    step(1'b1, 1'b1, 3'd0, 32'hFFFF_FF0F);
    check("wr_lat", {24'd0, out_port}, 32'hA5);
    rd(3'd0, "data_0f", 32'h0F);
    step(1'b1, 1'b1, 3'd1, 32'h30);
    check("set_out", {24'd0, out_port}, 32'h0F);
    rd(3'd0, "data_3f", 32'h3F);
    step(1'b1, 1'b1, 3'd2, 32'h03);
    check("clr_out", {24'd0, out_port}, 32'h3F);
    rd(3'd0, "data_3c", 32'h3C);
    step(1'b1, 1'b0, 3'd0, 32'h0);
    check("final_out", {24'd0, out_port}, 32'h3C);
    rd(3'd1, "rd_set", 32'h0);
    rd(3'd2, "rd_clr", 32'h0);
    rd(3'd6, "rd_6", 32'h0);

    // Blink with DIV=3
    step(1'b1, 1'b1, 3'd3, 32'h01);
    step(1'b1, 1'b1, 3'd0, 32'h81);
    step(1'b1, 1'b1, 3'd4, 32'd3);
    rd(3'd5, "div3_start", st(24'd0, 1'b1));
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 3'd0, 32'h0);
      rd(3'd5, "cnt_seq", st(24'(i % 4), 1'b1 ^ 1'(((i / 4) % 2))));
      check("blink_out", {24'd0, out_port},
            {24'd0, 7'b1000000, 1'b1 ^ 1'((((i - 1) / 4) % 2))});
    end

    // DIV write coinciding with terminal count
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      address = 3'd5;
      #1;
      if (readdata[24:1] == 24'd3) found = 1'b1;
      else step(1'b1, 1'b0, 3'd0, 32'h0);
    end
    check("wait_tc", {31'd0, found}, 32'd1);
    step(1'b1, 1'b1, 3'd4, 32'd5);
    rd(3'd5, "tc_div_wr", st(24'd0, 1'b1));
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b0, 3'd0, 32'h0);
      rd(3'd5, "div5_seq", st(24'(k % 6), (k < 6) ? 1'b1 : 1'b0));
    end

    // DIV=0 halts blinking, DIV=1 resumes
    step(1'b1, 1'b1, 3'd3, 32'hFF);
    step(1'b1, 1'b1, 3'd0, 32'hFF);
    step(1'b1, 1'b1, 3'd4, 32'd0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 3'd0, 32'h0);
      check("div0_out", {24'd0, out_port}, 32'hFF);
      rd(3'd5, "div0_status", st(24'd0, 1'b1));
    end
    step(1'b1, 1'b1, 3'd4, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 3'd0, 32'h0);
      rd(3'd5, "div1_seq", st(24'(k % 2), 1'b1 ^ 1'(((k / 2) % 2))));
    end

    // Reset during a DATA write mid-blink
    step(1'b1, 1'b0, 3'd0, 32'h0);
    step(1'b0, 1'b1, 3'd0, 32'h55);
    check("midrst_out", {24'd0, out_port}, 32'h0);
    rd(3'd0, "midrst_data", 32'hA5);
    rd(3'd3, "midrst_blink", 32'h0);
    rd(3'd4, "midrst_div", 32'd5000000);
    rd(3'd5, "midrst_status", st(24'd0, 1'b1));
    step(1'b1, 1'b0, 3'd0, 32'h0);
    check("midrst_rel", {24'd0, out_port}, 32'hA5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
